// File: rtl/lock_pkg.sv
// Shared types for the combination lock: FSM state and display status codes.
// Latency: n/a (types only).
// Backpressure: n/a.
package lock_pkg;

    typedef enum logic [2:0] {
        S_ENTRY   = 3'd0,
        S_OPEN    = 3'd1,
        S_CLOSED  = 3'd2,
        S_LOCKOUT = 3'd3,
        S_PROG    = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        STAT_BLANK  = 3'd0,
        STAT_OPEN   = 3'd1,
        STAT_CLOSED = 3'd2,
        STAT_ERROR  = 3'd3,
        STAT_LOCKED = 3'd4,
        STAT_PROG   = 3'd5
    } status_t;

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter timing the lockout window; done flags the final count.
// Latency: load visible next cycle; done is combinational from the count.
// Backpressure: none.
// Ports: clk, rst (sync, active high), load/load_val, en (decrement), count, done (count==1).
module lock_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         done
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == W'(1));

endmodule

// File: rtl/lock_ctrl.sv
// Combination lock: BCD digit entry, retry lockout and in-field reprogramming.
// Latency: every output is registered and reflects an enter one cycle later.
// Backpressure: none; each enter strobe is either consumed or ignored by state.
// Ports: clk, rst_n (sync, active high), digit_in/enter/prog inputs;
//        status, unlocked, err, digit_cnt, fail_cnt outputs.
module lock_ctrl
    import lock_pkg::*;
#(
    parameter int                      CODE_LEN     = 6,
    parameter int                      MAX_FAIL     = 3,
    parameter int                      LOCKOUT_CYC  = 16,
    parameter logic [CODE_LEN*4-1:0]   DEFAULT_CODE = 24'h703262
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit_in,
    input  logic       enter,
    input  logic       prog,
    output logic [2:0] status,
    output logic       unlocked,
    output logic       err,
    output logic [2:0] digit_cnt,
    output logic [1:0] fail_cnt
);

    localparam int              TW        = $clog2(LOCKOUT_CYC + 1);
    localparam logic [2:0]      LAST_IDX  = 3'(CODE_LEN - 1);
    localparam logic [1:0]      MAX_FAIL_V = 2'(MAX_FAIL);
    localparam logic [TW-1:0]   LOCK_LOAD = TW'(LOCKOUT_CYC);

    state_t                 state_q, state_d;
    logic [CODE_LEN*4-1:0]  code_q, shadow_q, shadow_wr;
    logic                   mismatch_q, mm_next;
    logic [2:0]             digit_cnt_q;
    logic [1:0]             fail_cnt_q, fail_inc;
    logic [3:0]             cur_nib;
    logic                   err_q, err_d, unlocked_q, unlocked_d;
    status_t                status_q, status_d;

    logic                   valid_dig, accepting, acc_ok, acc_bad, last_dig, state_chg;
    logic                   tmr_load, tmr_done;
    logic [TW-1:0]          tmr_count;

    // Digits are taken in ENTRY, and in PROG only while prog is still held
    // (a released prog aborts, even if a digit arrives on the same cycle).
    assign valid_dig = (digit_in <= 4'd9);
    assign accepting = (state_q == S_ENTRY) || ((state_q == S_PROG) && prog);
    assign acc_ok    = enter && accepting && valid_dig;
    assign acc_bad   = enter && accepting && !valid_dig;
    assign last_dig  = (digit_cnt_q == LAST_IDX);
    assign fail_inc  = fail_cnt_q + 2'd1;
    assign state_chg = (state_d != state_q);

    // First entered digit lives in the most significant nibble.
    always_comb begin
        cur_nib   = 4'd0;
        shadow_wr = shadow_q;
        for (int i = 0; i < CODE_LEN; i++) begin
            if ((CODE_LEN - 1 - i) == int'(digit_cnt_q)) begin
                cur_nib            = code_q[i*4 +: 4];
                shadow_wr[i*4 +: 4] = digit_in;
            end
        end
    end

    assign mm_next = mismatch_q | (digit_in != cur_nib);

    lock_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst_n),
        .load     (tmr_load),
        .en       (state_q == S_LOCKOUT),
        .load_val (LOCK_LOAD),
        .count    (tmr_count),
        .done     (tmr_done)
    );

    assign tmr_load = (state_q == S_ENTRY) && (state_d == S_LOCKOUT);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst_n) state_q <= S_ENTRY;
        else       state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ENTRY: begin
                if (acc_ok && last_dig) begin
                    if (!mm_next)                  state_d = S_OPEN;
                    else if (fail_inc == MAX_FAIL_V) state_d = S_LOCKOUT;
                    else                           state_d = S_CLOSED;
                end
            end
            S_OPEN:    if (enter)    state_d = prog ? S_PROG : S_ENTRY;
            S_CLOSED:  if (enter)    state_d = S_ENTRY;
            S_LOCKOUT: if (tmr_done) state_d = S_ENTRY;
            S_PROG: begin
                if (!prog)                 state_d = S_OPEN;
                else if (acc_ok && last_dig) state_d = S_ENTRY;
            end
            default:                   state_d = S_ENTRY;
        endcase
    end

    // FSM output logic: next values of the registered outputs
    always_comb begin
        err_d = err_q;
        if (acc_bad)                    err_d = 1'b1;
        else if (acc_ok || state_chg)   err_d = 1'b0;

        unlocked_d = (state_d == S_OPEN);

        case (state_d)
            S_OPEN:    status_d = STAT_OPEN;
            S_CLOSED:  status_d = STAT_CLOSED;
            S_LOCKOUT: status_d = STAT_LOCKED;
            S_PROG:    status_d = STAT_PROG;
            default:   status_d = STAT_BLANK;
        endcase
        if (err_d) status_d = STAT_ERROR;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            status_q   <= STAT_BLANK;
            unlocked_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            status_q   <= status_d;
            unlocked_q <= unlocked_d;
            err_q      <= err_d;
        end
    end

    // Datapath: digit counter, sticky mismatch, fail counter, code/shadow.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            digit_cnt_q <= 3'd0;
            mismatch_q  <= 1'b0;
            fail_cnt_q  <= 2'd0;
            code_q      <= DEFAULT_CODE;
            shadow_q    <= '0;
        end else begin
            if (state_chg) begin
                digit_cnt_q <= 3'd0;
                mismatch_q  <= 1'b0;
                shadow_q    <= '0;
            end else if (acc_ok) begin
                digit_cnt_q <= digit_cnt_q + 3'd1;
                if (state_q == S_ENTRY) mismatch_q <= mm_next;
                if (state_q == S_PROG)  shadow_q   <= shadow_wr;
            end

            if ((state_q == S_ENTRY) && acc_ok && last_dig) begin
                fail_cnt_q <= mm_next ? fail_inc : 2'd0;
            end else if ((state_q == S_LOCKOUT) && tmr_done) begin
                fail_cnt_q <= 2'd0;
            end

            // Completion merges the final digit so the whole code lands at once.
            if ((state_q == S_PROG) && (state_d == S_ENTRY)) begin
                code_q <= shadow_wr;
            end
        end
    end

    assign status    = status_q;
    assign unlocked  = unlocked_q;
    assign err       = err_q;
    assign digit_cnt = digit_cnt_q;
    assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_lock_ctrl.sv
module tb_lock_ctrl;

    localparam int CODE_LEN    = 6;
    localparam int MAX_FAIL    = 3;
    localparam int LOCKOUT_CYC = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] digit_in = 4'd0;
    logic       enter = 1'b0;
    logic       prog = 1'b0;
    logic [2:0] status;
    logic       unlocked;
    logic       err;
    logic [2:0] digit_cnt;
    logic [1:0] fail_cnt;

    always #5 clk = ~clk;

    lock_ctrl #(
        .CODE_LEN     (CODE_LEN),
        .MAX_FAIL     (MAX_FAIL),
        .LOCKOUT_CYC  (LOCKOUT_CYC),
        .DEFAULT_CODE (24'h703262)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .digit_in  (digit_in),
        .enter     (enter),
        .prog      (prog),
        .status    (status),
        .unlocked  (unlocked),
        .err       (err),
        .digit_cnt (digit_cnt),
        .fail_cnt  (fail_cnt)
    );

    int n_vec = 0;
    int n_mis = 0;

    // ---------------- reference model ----------------
    localparam int M_ENTRY = 0, M_OPEN = 1, M_CLOSED = 2, M_LOCK = 3, M_PROG = 4;
    int m_mode;
    int m_code[CODE_LEN];
    int m_buf[$];
    int m_fail;
    int m_left;
    bit m_err;

    task automatic model_reset();
        m_mode = M_ENTRY;
        m_code = '{7, 0, 3, 2, 6, 2};
        m_buf.delete();
        m_fail = 0;
        m_left = 0;
        m_err  = 0;
    endtask

    task automatic model_step(input bit r, input bit e, input int d, input bit p);
        bit ok;
        if (r) begin
            model_reset();
        end else begin
            case (m_mode)
                M_ENTRY: if (e) begin
                    if (d > 9) m_err = 1;
                    else begin
                        m_err = 0;
                        m_buf.push_back(d);
                        if (m_buf.size() == CODE_LEN) begin
                            ok = 1;
                            for (int i = 0; i < CODE_LEN; i++) if (m_buf[i] != m_code[i]) ok = 0;
                            m_buf.delete();
                            if (ok) begin
                                m_mode = M_OPEN;
                                m_fail = 0;
                            end else begin
                                m_fail++;
                                if (m_fail == MAX_FAIL) begin
                                    m_mode = M_LOCK;
                                    m_left = LOCKOUT_CYC;
                                end else m_mode = M_CLOSED;
                            end
                        end
                    end
                end
                M_OPEN:   if (e) m_mode = p ? M_PROG : M_ENTRY;
                M_CLOSED: if (e) m_mode = M_ENTRY;
                M_LOCK: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = M_ENTRY;
                        m_fail = 0;
                    end
                end
                default: begin
                    if (!p) begin
                        m_mode = M_OPEN;
                        m_buf.delete();
                        m_err = 0;
                    end else if (e) begin
                        if (d > 9) m_err = 1;
                        else begin
                            m_err = 0;
                            m_buf.push_back(d);
                            if (m_buf.size() == CODE_LEN) begin
                                for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_buf[i];
                                m_buf.delete();
                                m_mode = M_ENTRY;
                            end
                        end
                    end
                end
            endcase
        end
    endtask

    function automatic int m_status();
        if (m_err) return 3;
        case (m_mode)
            M_OPEN:   return 1;
            M_CLOSED: return 2;
            M_LOCK:   return 4;
            M_PROG:   return 5;
            default:  return 0;
        endcase
    endfunction

    // ---------------- drive / check ----------------
    task automatic apply(input bit r, input bit e, input int d, input bit p);
        @(negedge clk);
        rst_n    = r;
        enter    = e;
        digit_in = 4'(d);
        prog     = p;
        @(posedge clk);
        model_step(r, e, d, p);
        #1;
    endtask

    task automatic check(input string tag, input int st, input bit un, input bit er,
                         input int cnt, input int fl);
        n_vec++;
        if (status !== 3'(st) || unlocked !== un || err !== er ||
            digit_cnt !== 3'(cnt) || fail_cnt !== 2'(fl)) begin
            n_mis++;
            $display("FAIL %s: got status=%0d unlocked=%0b err=%0b digit_cnt=%0d fail_cnt=%0d, want %0d %0b %0b %0d %0d",
                     tag, status, unlocked, err, digit_cnt, fail_cnt, st, un, er, cnt, fl);
        end
    endtask

    task automatic check_model(input string tag);
        check(tag, m_status(), m_mode == M_OPEN, m_err, m_buf.size(), m_fail);
    endtask

    task automatic step(input bit r, input bit e, input int d, input bit p, input string tag);
        apply(r, e, d, p);
        check_model(tag);
    endtask

    task automatic enter_seq(input int a[CODE_LEN], input bit p, input string tag);
        for (int i = 0; i < CODE_LEN; i++) step(0, 1, a[i], p, tag);
    endtask

    typedef struct {
        bit       r;
        bit       e;
        int       d;
        bit       p;
        int       st;
        bit       un;
        bit       er;
        int       cnt;
        int       fl;
    } vec_t;

    vec_t tbl[23];
    int good[CODE_LEN]  = '{7, 0, 3, 2, 6, 2};
    int wrong[CODE_LEN] = '{7, 0, 3, 2, 6, 5};
    int ones[CODE_LEN]  = '{1, 1, 1, 1, 1, 1};
    int lock_cycles;

    initial begin
        model_reset();
        // reset, good code, relock, wrong code, error digit, good code
        tbl[0]  = '{1, 0, 0,  0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 7,  0, 0, 0, 0, 1, 0};
        tbl[2]  = '{0, 1, 0,  0, 0, 0, 0, 2, 0};
        tbl[3]  = '{0, 1, 3,  0, 0, 0, 0, 3, 0};
        tbl[4]  = '{0, 1, 2,  0, 0, 0, 0, 4, 0};
        tbl[5]  = '{0, 1, 6,  0, 0, 0, 0, 5, 0};
        tbl[6]  = '{0, 1, 2,  0, 1, 1, 0, 0, 0};
        tbl[7]  = '{0, 1, 0,  0, 0, 0, 0, 0, 0};
        tbl[8]  = '{0, 1, 7,  0, 0, 0, 0, 1, 0};
        tbl[9]  = '{0, 1, 0,  0, 0, 0, 0, 2, 0};
        tbl[10] = '{0, 1, 3,  0, 0, 0, 0, 3, 0};
        tbl[11] = '{0, 1, 2,  0, 0, 0, 0, 4, 0};
        tbl[12] = '{0, 1, 6,  0, 0, 0, 0, 5, 0};
        tbl[13] = '{0, 1, 5,  0, 2, 0, 0, 0, 1};
        tbl[14] = '{0, 1, 4,  0, 0, 0, 0, 0, 1};
        tbl[15] = '{0, 1, 7,  0, 0, 0, 0, 1, 1};
        tbl[16] = '{0, 1, 12, 0, 3, 0, 1, 1, 1};
        tbl[17] = '{0, 1, 0,  0, 0, 0, 0, 2, 1};
        tbl[18] = '{0, 1, 3,  0, 0, 0, 0, 3, 1};
        tbl[19] = '{0, 1, 2,  0, 0, 0, 0, 4, 1};
        tbl[20] = '{0, 1, 6,  0, 0, 0, 0, 5, 1};
        tbl[21] = '{0, 1, 2,  0, 1, 1, 0, 0, 0};
        tbl[22] = '{0, 0, 0,  0, 1, 1, 0, 0, 0};

        for (int i = 0; i < 23; i++) begin
            apply(tbl[i].r, tbl[i].e, tbl[i].d, tbl[i].p);
            check($sformatf("vec%0d", i), tbl[i].st, tbl[i].un, tbl[i].er, tbl[i].cnt, tbl[i].fl);
        end

        // Lockout: relock, then three wrong attempts with returns from CLOSED.
        step(0, 1, 0, 0, "relock");
        enter_seq(ones, 0, "wrong1");
        step(0, 1, 3, 0, "closed_ret1");
        enter_seq(ones, 0, "wrong2");
        step(0, 1, 3, 0, "closed_ret2");
        enter_seq(ones, 0, "wrong3");
        lock_cycles = (status == 3'd4) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            step(0, 1, 7, 1, "lockout_hold");
            if (status != 3'd4) break;
            lock_cycles++;
        end
        n_vec++;
        if (lock_cycles != LOCKOUT_CYC) begin
            n_mis++;
            $display("FAIL lockout_len: got %0d cycles, want %0d", lock_cycles, LOCKOUT_CYC);
        end

        // Reprogram to 111111, old code now closes, new code opens.
        enter_seq(good, 0, "open_default");
        step(0, 1, 0, 1, "enter_prog");
        enter_seq(ones, 1, "prog_ones");
        step(0, 0, 0, 0, "prog_release");
        enter_seq(good, 0, "old_code_closed");
        step(0, 1, 0, 0, "closed_ret3");
        enter_seq(ones, 0, "new_code_open");

        // Abort after 3 digits: code unchanged.
        step(0, 1, 0, 1, "enter_prog2");
        for (int i = 0; i < 3; i++) step(0, 1, 4, 1, "prog_partial");
        step(0, 0, 0, 0, "prog_abort");
        step(0, 1, 0, 0, "relock2");
        enter_seq(ones, 0, "code_kept");

        // prog release on the final programming digit: abort wins.
        step(0, 1, 0, 1, "enter_prog3");
        for (int i = 0; i < 5; i++) step(0, 1, 9, 1, "prog_five");
        step(0, 1, 9, 0, "abort_on_last");
        step(0, 1, 0, 0, "relock3");
        enter_seq(ones, 0, "code_kept2");

        // Reset with a simultaneous enter, then default code works again.
        step(1, 1, 7, 1, "reset_with_enter");
        enter_seq(good, 0, "default_after_reset");

        // Reset mid-lockout.
        step(0, 1, 0, 0, "relock4");
        for (int k = 0; k < 3; k++) begin
            enter_seq(wrong, 0, "wrong_again");
            if (k < 2) step(0, 1, 0, 0, "closed_ret4");
        end
        step(0, 0, 0, 0, "in_lockout");
        step(1, 0, 0, 0, "reset_in_lockout");

        // Randomized stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            bit r, e, p;
            int d;
            r = ($urandom_range(299, 0) == 0);
            e = ($urandom_range(1, 0) == 1);
            p = prog;
            if ($urandom_range(15, 0) == 0) p = ~p;
            if ($urandom_range(9, 0) < 7 && m_mode == M_ENTRY && m_buf.size() < CODE_LEN)
                d = m_code[m_buf.size()];
            else if ($urandom_range(9, 0) == 0)
                d = $urandom_range(15, 10);
            else
                d = $urandom_range(9, 0);
            step(r, e, d, p, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
